// File: rtl/fault_mem_pkg.sv
// Shared fault-type encodings for the configurable fault-injection memory.
// One 3-bit code selects the fault model; code 7 is reserved and behaves as NONE.
package fault_mem_pkg;

   localparam int FT_W = 3;

   localparam logic [FT_W-1:0] FT_NONE  = 3'd0;
   localparam logic [FT_W-1:0] FT_SAF0  = 3'd1;
   localparam logic [FT_W-1:0] FT_SAF1  = 3'd2;
   localparam logic [FT_W-1:0] FT_TF_UP = 3'd3;
   localparam logic [FT_W-1:0] FT_TF_DN = 3'd4;
   localparam logic [FT_W-1:0] FT_CFIN  = 3'd5;
   localparam logic [FT_W-1:0] FT_CFID  = 3'd6;
   localparam logic [FT_W-1:0] FT_RSVD  = 3'd7;

   function automatic logic is_coupling(input logic [FT_W-1:0] t);
      return (t == FT_CFIN) || (t == FT_CFID);
   endfunction

endpackage

// File: rtl/fault_mem_inject.sv
// Combinational fault model: given the active config and the array operation about to execute,
// produces the word to store, an optional victim-word override, the faulty read word and a hit flag.
module fault_mem_inject
   import fault_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int BIT_W      = $clog2(DATA_WIDTH)
) (
   input  logic [FT_W-1:0]       cfg_type,
   input  logic [ADDR_WIDTH-1:0] cfg_vaddr,
   input  logic [BIT_W-1:0]      cfg_vbit,
   input  logic [ADDR_WIDTH-1:0] cfg_aaddr,
   input  logic [BIT_W-1:0]      cfg_abit,
   input  logic                  op_valid,
   input  logic                  op_we,
   input  logic [ADDR_WIDTH-1:0] op_addr,
   input  logic [DATA_WIDTH-1:0] op_wdata,
   input  logic [DATA_WIDTH-1:0] old_word,
   input  logic [DATA_WIDTH-1:0] old_vic_word,
   input  logic                  ff_bit,
   output logic [DATA_WIDTH-1:0] wr_word,
   output logic                  vic_en,
   output logic [DATA_WIDTH-1:0] vic_word,
   output logic [DATA_WIDTH-1:0] rd_word,
   output logic                  hit,
   output logic                  ff_next
);

   logic [FT_W-1:0] eff_type;
   logic            vic_sel;
   logic            agg_sel;
   logic            old_vb;
   logic            new_vb;
   logic            old_ab;
   logic            new_ab;
   logic            cf_fire;

   always_comb begin
      eff_type = cfg_type;
      // A coupling fault whose aggressor is its own victim cell has no meaningful behaviour.
      if (cfg_type == FT_RSVD) begin
         eff_type = FT_NONE;
      end
      if (is_coupling(cfg_type) && (cfg_vaddr == cfg_aaddr) && (cfg_vbit == cfg_abit)) begin
         eff_type = FT_NONE;
      end

      vic_sel = (op_addr == cfg_vaddr);
      agg_sel = (op_addr == cfg_aaddr);
      old_vb  = old_word[cfg_vbit];
      new_vb  = op_wdata[cfg_vbit];
      old_ab  = old_word[cfg_abit];
      new_ab  = op_wdata[cfg_abit];
      cf_fire = agg_sel && ((eff_type == FT_CFIN) ? (old_ab ^ new_ab)
                                                  : ((eff_type == FT_CFID) && !old_ab && new_ab));

      wr_word  = op_wdata;
      vic_en   = 1'b0;
      vic_word = old_vic_word;
      rd_word  = old_word;
      hit      = 1'b0;
      ff_next  = ff_bit;

      if (op_valid && op_we) begin
         if (vic_sel) begin
            ff_next = new_vb;
         end
         case (eff_type)
            FT_SAF0, FT_SAF1: begin
               if (vic_sel) wr_word[cfg_vbit] = (eff_type == FT_SAF1);
            end
            FT_TF_UP: begin
               if (vic_sel && !old_vb && new_vb) wr_word[cfg_vbit] = 1'b0;
            end
            FT_TF_DN: begin
               if (vic_sel && old_vb && !new_vb) wr_word[cfg_vbit] = 1'b1;
            end
            FT_CFIN, FT_CFID: begin
               if (cf_fire) begin
                  if (vic_sel) begin
                     wr_word[cfg_vbit] = (eff_type == FT_CFIN) ? ~new_vb : 1'b0;
                  end else begin
                     vic_en             = 1'b1;
                     vic_word[cfg_vbit] = (eff_type == FT_CFIN) ? ~old_vic_word[cfg_vbit] : 1'b0;
                  end
               end
            end
            default: ;
         endcase
         hit = (wr_word != op_wdata) || (vic_en && (vic_word != old_vic_word));
      end else if (op_valid) begin
         if (vic_sel && ((eff_type == FT_SAF0) || (eff_type == FT_SAF1))) begin
            rd_word[cfg_vbit] = (eff_type == FT_SAF1);
         end
         // Reads are judged against the tracked fault-free value of the victim bit.
         hit = vic_sel && (eff_type != FT_NONE) && (rd_word[cfg_vbit] != ff_bit);
      end
   end

endmodule

// File: rtl/fault_mem_cfg.sv
// Single-port behavioural memory with one runtime-configurable fault; S1 input stage,
// array operation on the next edge, registered read data one edge later.
module fault_mem_cfg
   import fault_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int CNT_WIDTH  = 16,
   parameter int BIT_W      = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  write_read,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  cfg_load,
   input  logic [FT_W-1:0]       cfg_type,
   input  logic [ADDR_WIDTH-1:0] cfg_addr,
   input  logic [BIT_W-1:0]      cfg_bit,
   input  logic [ADDR_WIDTH-1:0] cfg_aaddr,
   input  logic [BIT_W-1:0]      cfg_abit,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  fault_hit,
   output logic [CNT_WIDTH-1:0]  hit_count
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic                  s1_valid_q, s1_valid_d;
   logic                  s1_we_q, s1_we_d;
   logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
   logic [DATA_WIDTH-1:0] s1_wdata_q, s1_wdata_d;

   logic [FT_W-1:0]       cfg_type_q, cfg_type_d;
   logic [ADDR_WIDTH-1:0] cfg_vaddr_q, cfg_vaddr_d;
   logic [BIT_W-1:0]      cfg_vbit_q, cfg_vbit_d;
   logic [ADDR_WIDTH-1:0] cfg_aaddr_q, cfg_aaddr_d;
   logic [BIT_W-1:0]      cfg_abit_q, cfg_abit_d;
   logic                  ff_bit_q, ff_bit_d;

   logic [DATA_WIDTH-1:0] rdata_int_q, rdata_int_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  fault_hit_q, fault_hit_d;
   logic [CNT_WIDTH-1:0]  hit_count_q, hit_count_d;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [DATA_WIDTH-1:0] old_word;
   logic [DATA_WIDTH-1:0] old_vic_word;
   logic [DATA_WIDTH-1:0] ld_word;
   logic [DATA_WIDTH-1:0] wr_word;
   logic                  vic_en;
   logic [DATA_WIDTH-1:0] vic_word;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  hit;
   logic                  ff_next;

   assign old_word     = mem_q[s1_addr_q];
   assign old_vic_word = mem_q[cfg_vaddr_q];
   assign ld_word      = mem_q[cfg_addr];

   fault_mem_inject #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .BIT_W      (BIT_W)
   ) u_inject (
      .cfg_type     (cfg_type_q),
      .cfg_vaddr    (cfg_vaddr_q),
      .cfg_vbit     (cfg_vbit_q),
      .cfg_aaddr    (cfg_aaddr_q),
      .cfg_abit     (cfg_abit_q),
      .op_valid     (s1_valid_q),
      .op_we        (s1_we_q),
      .op_addr      (s1_addr_q),
      .op_wdata     (s1_wdata_q),
      .old_word     (old_word),
      .old_vic_word (old_vic_word),
      .ff_bit       (ff_bit_q),
      .wr_word      (wr_word),
      .vic_en       (vic_en),
      .vic_word     (vic_word),
      .rd_word      (rd_word),
      .hit          (hit),
      .ff_next      (ff_next)
   );

   always_comb begin
      s1_valid_d = 1'b1;
      s1_we_d    = write_read;
      s1_addr_d  = address;
      s1_wdata_d = wdata;

      cfg_type_d  = cfg_type_q;
      cfg_vaddr_d = cfg_vaddr_q;
      cfg_vbit_d  = cfg_vbit_q;
      cfg_aaddr_d = cfg_aaddr_q;
      cfg_abit_d  = cfg_abit_q;
      ff_bit_d    = ff_next;
      if (cfg_load) begin
         cfg_type_d  = cfg_type;
         cfg_vaddr_d = cfg_addr;
         cfg_vbit_d  = cfg_bit;
         cfg_aaddr_d = cfg_aaddr;
         cfg_abit_d  = cfg_abit;
         // Seed the fault-free victim bit from the array as it will stand after this edge.
         ff_bit_d = (s1_valid_q && s1_we_q && (s1_addr_q == cfg_addr)) ? s1_wdata_q[cfg_bit]
                                                                       : ld_word[cfg_bit];
      end

      rdata_int_d = (s1_valid_q && !s1_we_q) ? rd_word : rdata_int_q;
      rdata_d     = rdata_int_q;
      fault_hit_d = hit;
      hit_count_d = (hit && !(&hit_count_q)) ? hit_count_q + CNT_WIDTH'(1) : hit_count_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_we_q     <= 1'b0;
         s1_addr_q   <= '0;
         s1_wdata_q  <= '0;
         cfg_type_q  <= FT_NONE;
         cfg_vaddr_q <= '0;
         cfg_vbit_q  <= '0;
         cfg_aaddr_q <= '0;
         cfg_abit_q  <= '0;
         ff_bit_q    <= 1'b0;
         rdata_int_q <= '0;
         rdata_q     <= '0;
         fault_hit_q <= 1'b0;
         hit_count_q <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_we_q     <= s1_we_d;
         s1_addr_q   <= s1_addr_d;
         s1_wdata_q  <= s1_wdata_d;
         cfg_type_q  <= cfg_type_d;
         cfg_vaddr_q <= cfg_vaddr_d;
         cfg_vbit_q  <= cfg_vbit_d;
         cfg_aaddr_q <= cfg_aaddr_d;
         cfg_abit_q  <= cfg_abit_d;
         ff_bit_q    <= ff_bit_d;
         rdata_int_q <= rdata_int_d;
         rdata_q     <= rdata_d;
         fault_hit_q <= fault_hit_d;
         hit_count_q <= hit_count_d;
      end
   end

   // Array contents survive reset; only the pending S1 operation is discarded.
   always_ff @(posedge clk) begin
      if (!rst && s1_valid_q && s1_we_q) begin
         mem_q[s1_addr_q] <= wr_word;
      end
      if (!rst && vic_en) begin
         mem_q[cfg_vaddr_q] <= vic_word;
      end
   end

   assign rdata     = rdata_q;
   assign fault_hit = fault_hit_q;
   assign hit_count = hit_count_q;

endmodule

// File: tb/tb_fault_mem_cfg.sv
// Directed bench for fault_mem_cfg: each fault type with hand-computed words, hit pulses and
// a saturating hit-count model, plus reset-drop and reset-of-config behaviour.
module tb_fault_mem_cfg;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int CW = 4;
   localparam int BW = 3;
   localparam logic [AW-1:0] IDLE_ADDR = 4'hF;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          write_read = 1'b0;
   logic [AW-1:0] address = IDLE_ADDR;
   logic [DW-1:0] wdata = '0;
   logic          cfg_load = 1'b0;
   logic [2:0]    cfg_type = '0;
   logic [AW-1:0] cfg_addr = '0;
   logic [BW-1:0] cfg_bit = '0;
   logic [AW-1:0] cfg_aaddr = '0;
   logic [BW-1:0] cfg_abit = '0;
   logic [DW-1:0] rdata;
   logic          fault_hit;
   logic [CW-1:0] hit_count;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   fault_mem_cfg #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .write_read (write_read),
      .address    (address),
      .wdata      (wdata),
      .cfg_load   (cfg_load),
      .cfg_type   (cfg_type),
      .cfg_addr   (cfg_addr),
      .cfg_bit    (cfg_bit),
      .cfg_aaddr  (cfg_aaddr),
      .cfg_abit   (cfg_abit),
      .rdata      (rdata),
      .fault_hit  (fault_hit),
      .hit_count  (hit_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      write_read = 1'b0;
      address    = IDLE_ADDR;
      wdata      = '0;
      cfg_load   = 1'b0;
   endtask

   task automatic note_hit(input logic exp_hit);
      if (exp_hit) exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
   endtask

   task automatic set_cfg(input logic [2:0] t, input logic [AW-1:0] va, input logic [BW-1:0] vb,
                          input logic [AW-1:0] aa, input logic [BW-1:0] ab);
      cfg_type  = t;
      cfg_addr  = va;
      cfg_bit   = vb;
      cfg_aaddr = aa;
      cfg_abit  = ab;
   endtask

   task automatic load_cfg(input logic [2:0] t, input logic [AW-1:0] va, input logic [BW-1:0] vb,
                           input logic [AW-1:0] aa, input logic [BW-1:0] ab);
      set_cfg(t, va, vb, aa, ab);
      cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic exp_hit,
                     input logic ld);
      write_read = 1'b1;
      address    = a;
      wdata      = d;
      cfg_load   = ld;
      tick();
      idle();
      tick();
      note_hit(exp_hit);
      check_eq("wr_hit", fault_hit, exp_hit);
      check_eq("wr_cnt", hit_count, exp_cnt);
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input logic exp_hit);
      write_read = 1'b0;
      address    = a;
      tick();
      idle();
      tick();
      note_hit(exp_hit);
      check_eq("rd_hit", fault_hit, exp_hit);
      check_eq("rd_cnt", hit_count, exp_cnt);
      tick();
      check_eq("rd_data", rdata, exp);
   endtask

   initial begin
      idle();
      rst = 1'b1;
      tick();
      tick();
      check_eq("rst_rdata", rdata, 8'h00);
      check_eq("rst_hit", fault_hit, 1'b0);
      check_eq("rst_cnt", hit_count, 4'h0);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) wr(AW'(i), 8'h00, 1'b0, 1'b0);

      // Basic write/read with latency: rdata still old one edge before it is due.
      wr(4'd3, 8'hA5, 1'b0, 1'b0);
      write_read = 1'b0;
      address    = 4'd3;
      tick();
      idle();
      tick();
      check_eq("lat_early", rdata, 8'h00);
      tick();
      check_eq("lat_data", rdata, 8'hA5);
      check_eq("lat_cnt", hit_count, 4'h0);

      // SAF1 word 5 bit 2
      load_cfg(3'd2, 4'd5, 3'd2, 4'd0, 3'd0);
      wr(4'd5, 8'h00, 1'b1, 1'b0);
      rd(4'd5, 8'h04, 1'b1);
      check_eq("saf_cnt", hit_count, 4'd2);

      // TF_UP word 7 bit 4
      load_cfg(3'd3, 4'd7, 3'd4, 4'd0, 3'd0);
      wr(4'd7, 8'h00, 1'b0, 1'b0);
      wr(4'd7, 8'hFF, 1'b1, 1'b0);
      rd(4'd7, 8'hEF, 1'b1);
      wr(4'd6, 8'h00, 1'b0, 1'b0);
      wr(4'd6, 8'hFF, 1'b0, 1'b0);
      rd(4'd6, 8'hFF, 1'b0);

      // CFIN victim 2/b0, aggressor 9/b3
      load_cfg(3'd5, 4'd2, 3'd0, 4'd9, 3'd3);
      wr(4'd2, 8'h00, 1'b0, 1'b0);
      wr(4'd9, 8'h00, 1'b0, 1'b0);
      wr(4'd9, 8'h08, 1'b1, 1'b0);
      rd(4'd2, 8'h01, 1'b1);
      wr(4'd9, 8'h00, 1'b1, 1'b0);
      rd(4'd2, 8'h00, 1'b0);

      // CFID victim 1/b7, aggressor 1/b0, loaded in the same cycle as the first write
      set_cfg(3'd6, 4'd1, 3'd7, 4'd1, 3'd0);
      wr(4'd1, 8'h80, 1'b0, 1'b1);
      wr(4'd1, 8'h81, 1'b1, 1'b0);
      rd(4'd1, 8'h01, 1'b1);
      check_eq("cfid_cnt", hit_count, 4'd9);

      // Reserved code acts as NONE
      load_cfg(3'd7, 4'd1, 3'd7, 4'd1, 3'd0);
      rd(4'd1, 8'h01, 1'b0);

      // Reset one cycle after a write request drops it and returns config to NONE
      wr(4'd4, 8'h3C, 1'b0, 1'b0);
      load_cfg(3'd2, 4'd4, 3'd0, 4'd0, 3'd0);
      write_read = 1'b1;
      address    = 4'd4;
      wdata      = 8'h55;
      tick();
      idle();
      rst = 1'b1;
      tick();
      check_eq("rst2_rdata", rdata, 8'h00);
      check_eq("rst2_hit", fault_hit, 1'b0);
      check_eq("rst2_cnt", hit_count, 4'h0);
      tick();
      rst = 1'b0;
      exp_cnt = 0;
      rd(4'd4, 8'h3C, 1'b0);

      // Saturation of the 4-bit hit counter
      load_cfg(3'd2, 4'd0, 3'd0, 4'd0, 3'd0);
      for (int i = 0; i < 20; i++) wr(4'd0, 8'h00, 1'b1, 1'b0);
      check_eq("sat_cnt", hit_count, 4'hF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
